// File: rtl/datamem_dp.sv
// datamem_dp: simple dual-port data memory (one write port, one read port)
// with a post-reset clear sweep, write-first same-address bypass and
// registered one-cycle-latency reads.
//
// Optional feature macro: DATAMEM_PARITY_EN
//   defined   -> each word carries an even-parity bit; par_inject stores the
//                inverted bit so the error path can be exercised; parity_err
//                flags a mismatch alongside read_valid.
//   undefined -> no parity storage, par_inject ignored, parity_err tied 0.
module datamem_dp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              par_inject,
  input  logic              mem_read,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              busy,
  output logic              parity_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;

  // Storage array: never reset, zeroed by the clear sweep instead.
  logic [DATA_W-1:0] mem [DEPTH];

  // Unified write port: the sweep and user writes share it, they never overlap.
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic              bypass;

  // Select the write-port source and qualify requests with the FSM state.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = clr_ptr;
    wr_data = '0;
    rd_en   = 1'b0;
    bypass  = 1'b0;
    if (!rst) begin
      if (state == CLEAR) begin
        wr_en = 1'b1;
      end else begin
        rd_en = mem_read;
        if (mem_write) begin
          wr_en   = 1'b1;
          wr_addr = write_addr;
          wr_data = write_data;
        end
        bypass = mem_read && mem_write && (write_addr == read_addr);
      end
    end
  end

  // Control FSM: sweep every word once after reset, then serve requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == LAST_ADDR) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: begin
          busy <= 1'b0;
        end
        default: begin
          state <= CLEAR;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // Array write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read with write-first bypass on a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data  <= '0;
      read_valid <= 1'b0;
    end else begin
      read_valid <= rd_en;
      if (rd_en) begin
        read_data <= bypass ? write_data : mem[read_addr];
      end
    end
  end

`ifdef DATAMEM_PARITY_EN
  // Stored parity bits, one per word, written alongside the data array.
  logic par_mem [DEPTH];
  logic wr_par;
  logic rd_par;

  // Sweep stores correct parity of zero (0); user writes may invert it.
  assign wr_par = (state == CLEAR) ? 1'b0 : ((^write_data) ^ par_inject);

  // Parity array write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      par_mem[wr_addr] <= wr_par;
    end
  end

  // Fetch the stored parity bit in step with read_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_par <= 1'b0;
    end else if (rd_en) begin
      rd_par <= bypass ? wr_par : par_mem[read_addr];
    end
  end

  // Recompute parity on the registered word; only meaningful with read_valid.
  assign parity_err = read_valid & (rd_par ^ (^read_data));
`else
  logic unused_par_inject;
  assign unused_par_inject = par_inject;
  assign parity_err        = 1'b0;
`endif

endmodule

// File: doc/datamem_dp.md
DATAMEM_DP -- requirements
Module: datamem_dp

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data word width in bits, legal range 1..32.
REQ-002 SHALL have parameter ADDR_W, default 8: address width in bits; depth is DEPTH = 2**ADDR_W words.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 SHALL have port mem_write  input  1  write request, sampled at the clk edge.
REQ-006 SHALL have port write_addr  input  ADDR_W  write word address.
REQ-007 SHALL have port write_data  input  DATA_W  write data.
REQ-008 SHALL have port par_inject  input  1  with mem_write, stores inverted parity (test hook).
REQ-009 SHALL have port mem_read  input  1  read request, sampled at the clk edge.
REQ-010 SHALL have port read_addr  input  ADDR_W  read word address.
REQ-011 SHALL have port read_data  output  DATA_W  registered read data.
REQ-012 SHALL have port read_valid  output  1  one-cycle pulse: read_data holds data of an accepted read.
REQ-013 SHALL have port busy  output  1  high while the post-reset clear sweep runs; requests are ignored.
REQ-014 SHALL have port parity_err  output  1  qualifies read_valid: stored parity mismatch on that read.

Function
REQ-015 SHALL implement a two-state FSM: CLEAR and READY.
REQ-016 In CLEAR: write 0 (correct parity) to word clr_ptr each cycle, clr_ptr 0 -> DEPTH-1; after writing DEPTH-1, go to READY.
REQ-017 busy SHALL be 1 in CLEAR and 0 in READY; clear takes exactly DEPTH cycles after rst deasserts.
REQ-018 In CLEAR, mem_write and mem_read SHALL be dropped: no array change, no read_valid.
REQ-019 In READY, mem_write=1 SHALL store write_data at write_addr on that edge.
REQ-020 In READY, mem_read=1 at edge t SHALL give read_data = mem[read_addr] and read_valid=1 after edge t; latency 1 cycle.
REQ-021 read_valid SHALL be 0 in any cycle after an edge without an accepted read; read_data then holds its last value.
REQ-022 Same-edge read and write to the same address SHALL be write-first: read_data = write_data.
REQ-023 Same-edge read and write to different addresses SHALL both complete independently.
REQ-024 Back-to-back reads SHALL be accepted every cycle; read_valid stays high, no bubbles.
REQ-025 Addresses SHALL wrap naturally at ADDR_W bits; no out-of-range access exists.

Reset
REQ-026 rst=1 SHALL set: FSM=CLEAR, clr_ptr=0, read_data=0, read_valid=0, parity_err=0, busy=1.
REQ-027 rst asserted mid-clear or mid-read SHALL discard in-flight reads and restart the clear sweep at address 0.
REQ-028 Array contents SHALL NOT be reset directly; the clear sweep zeroes them.

Configuration
REQ-029 Macro DATAMEM_PARITY_EN SHALL control parity.
REQ-030 With DATAMEM_PARITY_EN defined: each word stores an even-parity bit over write_data. par_inject=1 stores the inverted parity bit. parity_err=1 with read_valid when the recomputed parity of the read word mismatches the stored bit. On a write-first bypass, parity_err reflects the parity being written.
REQ-031 Without DATAMEM_PARITY_EN: no parity storage; par_inject ignored; parity_err tied 0.

Verification
REQ-032 Reset, release rst, default params -> busy=1 for exactly 256 cycles, then 0. A read of address 0x37 returns 0x00 with read_valid=1 one cycle later.
REQ-033 After clear, write 0xA5 to 0x10, next cycle read 0x10 -> read_data=0xA5, read_valid=1 exactly one cycle after the read edge.
REQ-034 Same edge: write 0x3C to 0x20 and read 0x20 -> read_data=0x3C (write-first). Same edge: write 0x11 to 0x21 and read 0x10 -> 0xA5.
REQ-035 Mid-clear (cycle 100), pulse rst -> busy remains 1 for 256 cycles after release. A write of 0xFF to 0x05 during busy is dropped; 0x05 later reads 0x00.
REQ-036 With DATAMEM_PARITY_EN: write 0x81 to 0x40 with par_inject=1, then read 0x40 -> read_data=0x81, parity_err=1. Rewrite 0x81 with par_inject=0 and read -> parity_err=0. Without the macro -> parity_err=0 in both cases.
REQ-037 Reads of 0x00,0x01,0x02 on three consecutive edges -> read_valid high for three consecutive cycles, in address order, then low.
